// File: rtl/register_tree_kv_pkg.sv
// register_tree_kv_pkg: shared phase type and key-ordering helper for the register-tree priority queue
package register_tree_kv_pkg;

    typedef enum logic {CAS_EVEN, CAS_ODD} phase_t;

    localparam int KEY_MAX = 64;

    // a strictly beats b: valid beats invalid, then smaller key (larger when max_heap)
    function automatic logic better(input logic a_valid, input logic [KEY_MAX-1:0] a_key,
                                    input logic b_valid, input logic [KEY_MAX-1:0] b_key,
                                    input logic max_heap);
        return a_valid && (!b_valid || (max_heap ? a_key > b_key : a_key < b_key));
    endfunction

endpackage

// File: rtl/register_tree_kv_if.sv
// register_tree_kv_if: push/pop handshake and status bundle of the register-tree priority queue
interface register_tree_kv_if #(
    parameter int QUEUE_SIZE = 64,
    parameter int KEY_WIDTH  = 16,
    parameter int VAL_WIDTH  = 16
);
    logic                        i_push_valid;
    logic                        o_push_ready;
    logic [KEY_WIDTH-1:0]        i_push_key;
    logic [VAL_WIDTH-1:0]        i_push_val;
    logic                        i_pop_valid;
    logic                        o_pop_ready;
    logic                        o_top_valid;
    logic [KEY_WIDTH-1:0]        o_top_key;
    logic [VAL_WIDTH-1:0]        o_top_val;
    logic [$clog2(QUEUE_SIZE):0] o_count;
    logic                        o_full;
    logic                        o_empty;
    logic                        o_settled;

    modport master (
        output i_push_valid, i_push_key, i_push_val, i_pop_valid,
        input  o_push_ready, o_pop_ready, o_top_valid, o_top_key, o_top_val,
               o_count, o_full, o_empty, o_settled
    );

    modport slave (
        input  i_push_valid, i_push_key, i_push_val, i_pop_valid,
        output o_push_ready, o_pop_ready, o_top_valid, o_top_key, o_top_val,
               o_count, o_full, o_empty, o_settled
    );
endinterface

// File: rtl/register_tree_kv_comparator.sv
// kv_comparator: combinational compare-swap of one {parent,left,right} triple; the best entry rises to the parent
module kv_comparator
    import register_tree_kv_pkg::*;
#(
    parameter int KEY_WIDTH = 16,
    parameter int VAL_WIDTH = 16,
    parameter int MAX_HEAP  = 0
) (
    input  logic [KEY_WIDTH+VAL_WIDTH:0] p_in,
    input  logic [KEY_WIDTH+VAL_WIDTH:0] l_in,
    input  logic [KEY_WIDTH+VAL_WIDTH:0] r_in,
    output logic [KEY_WIDTH+VAL_WIDTH:0] p_out,
    output logic [KEY_WIDTH+VAL_WIDTH:0] l_out,
    output logic [KEY_WIDTH+VAL_WIDTH:0] r_out
);
    typedef struct packed {
        logic                 valid;
        logic [KEY_WIDTH-1:0] key;
        logic [VAL_WIDTH-1:0] val;
    } node_t;

    node_t p, l, r;
    logic  l_p, r_p, r_l, r_win, l_win;

    function automatic logic beats(input node_t a, input node_t b);
        return better(a.valid, KEY_MAX'(a.key), b.valid, KEY_MAX'(b.key), MAX_HEAP != 0);
    endfunction

    assign p = p_in;
    assign l = l_in;
    assign r = r_in;

    // ties keep the parent in place and favour the left child
    assign l_p   = beats(l, p);
    assign r_p   = beats(r, p);
    assign r_l   = beats(r, l);
    assign r_win = r_p && r_l;
    assign l_win = l_p && !r_win;

    assign p_out = r_win ? r_in : l_win ? l_in : p_in;
    assign l_out = l_win ? p_in : l_in;
    assign r_out = r_win ? p_in : r_in;
endmodule

// File: rtl/register_tree_kv.sv
// register_tree_kv: register-tree priority queue of key+payload entries with alternating-level compare-swap settling
module register_tree_kv
    import register_tree_kv_pkg::*;
#(
    parameter int QUEUE_SIZE = 64,
    parameter int KEY_WIDTH  = 16,
    parameter int VAL_WIDTH  = 16,
    parameter int MAX_HEAP   = 0,
    parameter int STRICT     = 1
) (
    input logic               CLK,
    input logic               RST,
    register_tree_kv_if.slave bus
);
    localparam int DEPTH = $clog2(QUEUE_SIZE);
    localparam int NODES = 2 * QUEUE_SIZE - 1;
    localparam int LEAF0 = QUEUE_SIZE - 1;
    localparam int CW    = DEPTH + 1;
    localparam int IW    = $clog2(NODES);
    localparam int SW    = $clog2(2 * DEPTH + 2);
    localparam logic [SW-1:0] SETTLE_MAX = SW'(2 * DEPTH + 1);

    typedef struct packed {
        logic                 valid;
        logic [KEY_WIDTH-1:0] key;
        logic [VAL_WIDTH-1:0] val;
    } node_t;

    node_t          node     [NODES];
    node_t          cas_next [NODES];
    node_t          cas_p    [LEAF0];
    node_t          cas_l    [LEAF0];
    node_t          cas_r    [LEAF0];
    logic [CW-1:0]  count;
    logic [SW-1:0]  settle;
    phase_t         phase;
    logic [IW-1:0]  free_slot;
    logic           free_any;
    logic           full, settled, push_ready, pop_ready;
    logic           do_rep, do_push, do_pop;

    for (genvar i = 0; i < LEAF0; i++) begin : g_cmp
        kv_comparator #(
            .KEY_WIDTH(KEY_WIDTH),
            .VAL_WIDTH(VAL_WIDTH),
            .MAX_HEAP (MAX_HEAP)
        ) u_cmp (
            .p_in (node[i]),
            .l_in (node[2*i+1]),
            .r_in (node[2*i+2]),
            .p_out(cas_p[i]),
            .l_out(cas_l[i]),
            .r_out(cas_r[i])
        );
    end

    // a node is either the parent of an active triple or a child of one, never both
    for (genvar i = 0; i < NODES; i++) begin : g_next
        localparam int     LVL = $clog2(i + 2) - 1;
        localparam phase_t OWN = (LVL % 2) ? CAS_ODD : CAS_EVEN;
        node_t own_v, from_par;
        if (i < LEAF0) begin : g_own
            assign own_v = cas_p[i];
        end else begin : g_leaf
            assign own_v = node[i];
        end
        if (i == 0) begin : g_root
            assign from_par = node[0];
        end else if (i % 2) begin : g_left
            assign from_par = cas_l[(i-1)/2];
        end else begin : g_right
            assign from_par = cas_r[(i-1)/2];
        end
        assign cas_next[i] = (phase == OWN) ? own_v : from_par;
    end

    always_comb begin
        free_any  = 1'b0;
        free_slot = '0;
        for (int j = QUEUE_SIZE - 1; j >= 0; j--)
            if (!node[LEAF0+j].valid) begin
                free_any  = 1'b1;
                free_slot = IW'(LEAF0 + j);
            end
    end

    assign full       = count == CW'(QUEUE_SIZE);
    assign settled    = settle == '0;
    assign push_ready = !full && free_any;
    assign pop_ready  = node[0].valid && (settled || STRICT == 0);
    assign do_rep     = bus.i_push_valid && bus.i_pop_valid && pop_ready;
    assign do_push    = bus.i_push_valid && push_ready && !do_rep;
    assign do_pop     = bus.i_pop_valid && pop_ready && !bus.i_push_valid;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int j = 0; j < NODES; j++) node[j] <= '0;
            count  <= '0;
            settle <= '0;
            phase  <= CAS_EVEN;
        end else if (do_rep) begin
            node[0] <= '{valid: 1'b1, key: bus.i_push_key, val: bus.i_push_val};
            settle  <= SETTLE_MAX;
            phase   <= CAS_EVEN;
        end else if (do_push) begin
            node[free_slot] <= '{valid: 1'b1, key: bus.i_push_key, val: bus.i_push_val};
            count           <= count + 1'b1;
            settle          <= SETTLE_MAX;
            phase           <= CAS_EVEN;
        end else if (do_pop) begin
            node[0] <= '0;
            count   <= count - 1'b1;
            settle  <= (settle > SW'(2)) ? settle : SW'(2);
            phase   <= CAS_EVEN;
        end else begin
            node   <= cas_next;
            settle <= settled ? settle : settle - 1'b1;
            phase  <= (phase == CAS_EVEN) ? CAS_ODD : CAS_EVEN;
        end
    end

    assign bus.o_push_ready = push_ready;
    assign bus.o_pop_ready  = pop_ready;
    assign bus.o_top_valid  = node[0].valid;
    assign bus.o_top_key    = node[0].valid ? node[0].key : '0;
    assign bus.o_top_val    = node[0].valid ? node[0].val : '0;
    assign bus.o_count      = count;
    assign bus.o_full       = full;
    assign bus.o_empty      = count == '0;
    assign bus.o_settled    = settled;
endmodule

// File: tb/tb_register_tree_kv.sv
// tb_register_tree_kv: directed checks of min-heap, max-heap and non-strict register-tree queues (QUEUE_SIZE=4)
module tb_register_tree_kv;
    localparam int QS = 4;
    localparam int KW = 16;
    localparam int VW = 16;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          push_valid [3];
    logic          pop_valid  [3];
    logic [KW-1:0] push_key   [3];
    logic [VW-1:0] push_val   [3];
    logic          push_ready [3];
    logic          pop_ready  [3];
    logic          top_valid  [3];
    logic [KW-1:0] top_key    [3];
    logic [VW-1:0] top_val    [3];
    logic [2:0]    count      [3];
    logic          full       [3];
    logic          empty      [3];
    logic          settled    [3];
    int            n_tests = 0;
    int            n_fail  = 0;

    always #5 CLK = ~CLK;

    // instance 0: min-heap strict, 1: max-heap strict, 2: min-heap non-strict
    for (genvar g = 0; g < 3; g++) begin : g_dut
        register_tree_kv_if #(.QUEUE_SIZE(QS), .KEY_WIDTH(KW), .VAL_WIDTH(VW)) bus ();
        assign bus.i_push_valid = push_valid[g];
        assign bus.i_push_key   = push_key[g];
        assign bus.i_push_val   = push_val[g];
        assign bus.i_pop_valid  = pop_valid[g];
        assign push_ready[g]    = bus.o_push_ready;
        assign pop_ready[g]     = bus.o_pop_ready;
        assign top_valid[g]     = bus.o_top_valid;
        assign top_key[g]       = bus.o_top_key;
        assign top_val[g]       = bus.o_top_val;
        assign count[g]         = bus.o_count;
        assign full[g]          = bus.o_full;
        assign empty[g]         = bus.o_empty;
        assign settled[g]       = bus.o_settled;
        register_tree_kv #(
            .QUEUE_SIZE(QS),
            .KEY_WIDTH (KW),
            .VAL_WIDTH (VW),
            .MAX_HEAP  (g == 1 ? 1 : 0),
            .STRICT    (g == 2 ? 0 : 1)
        ) u_dut (
            .CLK(CLK),
            .RST(RST),
            .bus(bus)
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset;
        for (int d = 0; d < 3; d++) begin
            push_valid[d] = 1'b0;
            pop_valid[d]  = 1'b0;
            push_key[d]   = '0;
            push_val[d]   = '0;
        end
        RST = 1'b1;
        tick;
        tick;
        RST = 1'b0;
    endtask

    task automatic push(input int d, input logic [KW-1:0] k, input logic [VW-1:0] v);
        int t = 0;
        push_valid[d] = 1'b1;
        push_key[d]   = k;
        push_val[d]   = v;
        while (!push_ready[d] && t < 50) begin
            tick;
            t++;
        end
        if (t == 50) check("push_timeout", 0, 1);
        tick;
        push_valid[d] = 1'b0;
    endtask

    task automatic pop(input int d, input logic [KW-1:0] ek, input logic [VW-1:0] ev, input string tag);
        int t = 0;
        pop_valid[d] = 1'b1;
        while (!pop_ready[d] && t < 50) begin
            tick;
            t++;
        end
        if (t == 50) check({tag, "_timeout"}, 0, 1);
        check({tag, "_key"}, top_key[d], ek);
        check({tag, "_val"}, top_val[d], ev);
        tick;
        pop_valid[d] = 1'b0;
    endtask

    task automatic wait_settled(input int d);
        int t = 0;
        while (!settled[d] && t < 50) begin
            tick;
            t++;
        end
        if (t == 50) check("settle_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int low;
        do_reset;
        check("rst_top_valid", top_valid[0], 0);
        check("rst_count", count[0], 0);
        check("rst_empty", empty[0], 1);
        check("rst_full", full[0], 0);
        check("rst_settled", settled[0], 1);
        check("rst_push_ready", push_ready[0], 1);
        check("rst_pop_ready", pop_ready[0], 0);

        push(0, 5, 16'h50);
        push(0, 3, 16'h30);
        push(0, 9, 16'h90);
        push(0, 1, 16'h10);
        wait_settled(0);
        check("fill_top_key", top_key[0], 1);
        check("fill_top_val", top_val[0], 16'h10);
        check("fill_full", full[0], 1);
        check("fill_push_ready", push_ready[0], 0);
        check("fill_count", count[0], 4);
        push_valid[0] = 1'b1;
        push_key[0]   = 2;
        tick;
        push_valid[0] = 1'b0;
        check("full_push_ignored_count", count[0], 4);
        check("full_push_ignored_top", top_key[0], 1);

        pop(0, 1, 16'h10, "min_pop0");
        pop(0, 3, 16'h30, "min_pop1");
        pop(0, 5, 16'h50, "min_pop2");
        pop(0, 9, 16'h90, "min_pop3");
        check("drain_empty", empty[0], 1);
        check("drain_pop_ready", pop_ready[0], 0);
        check("drain_top_valid", top_valid[0], 0);
        check("drain_top_key", top_key[0], 0);
        pop_valid[0] = 1'b1;
        tick;
        pop_valid[0] = 1'b0;
        check("empty_pop_ignored", count[0], 0);

        push(1, 0, 16'hA0);
        push(1, 7, 16'hB0);
        push(1, 7, 16'hC0);
        push(1, 2, 16'hD0);
        wait_settled(1);
        check("max_top_key", top_key[1], 7);
        pop(1, 7, 16'hB0, "max_pop0");
        pop(1, 7, 16'hC0, "max_pop1");
        pop(1, 2, 16'hD0, "max_pop2");
        pop(1, 0, 16'hA0, "max_pop3");
        check("max_drain_valid", top_valid[1], 0);

        push(0, 4, 16'h41);
        push(0, 8, 16'h81);
        wait_settled(0);
        check("rep_pre_top", top_key[0], 4);
        push_valid[0] = 1'b1;
        push_key[0]   = 6;
        push_val[0]   = 16'h61;
        pop_valid[0]  = 1'b1;
        check("rep_pop_ready", pop_ready[0], 1);
        check("rep_out_key", top_key[0], 4);
        check("rep_out_val", top_val[0], 16'h41);
        tick;
        push_valid[0] = 1'b0;
        pop_valid[0]  = 1'b0;
        check("rep_count", count[0], 2);
        check("rep_root_key", top_key[0], 6);
        check("rep_settled", settled[0], 0);
        wait_settled(0);
        check("rep_top_key", top_key[0], 6);
        pop(0, 6, 16'h61, "rep_pop0");
        pop(0, 8, 16'h81, "rep_pop1");

        push(0, 4, 16'h42);
        wait_settled(0);
        push(0, 6, 16'h62);
        pop_valid[0] = 1'b1;
        low = 0;
        while (!pop_ready[0] && low < 20) begin
            low++;
            tick;
        end
        check("strict_latency", low, 5);
        check("strict_pop_key", top_key[0], 4);
        tick;
        pop_valid[0] = 1'b0;
        pop(0, 6, 16'h62, "strict_pop1");

        push(2, 4, 16'h43);
        wait_settled(2);
        push(2, 6, 16'h63);
        check("loose_pop_ready", pop_ready[2], 1);
        check("loose_settled", settled[2], 0);
        pop(2, 4, 16'h43, "loose_pop0");
        pop(2, 6, 16'h63, "loose_pop1");

        do_reset;
        push(0, 1, 16'h11);
        push(0, 2, 16'h22);
        push(0, 3, 16'h33);
        check("mid_count", count[0], 3);
        check("mid_settled", settled[0], 0);
        #2;
        RST = 1'b1;
        #1;
        check("arst_count", count[0], 0);
        check("arst_top_valid", top_valid[0], 0);
        check("arst_settled", settled[0], 1);
        check("arst_empty", empty[0], 1);
        check("arst_push_ready", push_ready[0], 1);
        tick;
        RST = 1'b0;
        push(0, 7, 16'h77);
        wait_settled(0);
        check("post_rst_top_key", top_key[0], 7);
        check("post_rst_top_val", top_val[0], 16'h77);
        check("post_rst_count", count[0], 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
